dsp_pipe_delay: RTL and testbench

- Parametrised multi-channel input pipeline for the DSP48A1 slice datapath; successor to the single-register/bypass input stage.
- Provides a run-time selectable latency of 0..DEPTH register stages across CHANNELS parallel lanes.
- Adds per-stage valid tracking, clock-enable stall, synchronous flush and a "primed" status derived from a fill counter.
- Sits between the slice input ports (A/B/C/D) and the pre-adder/multiplier, replacing the fixed A0/A1/B0/B1-style registers.

---
 rtl/dsp_pipe_delay.sv | 80 ++++++++
 tb/tb_dsp_pipe_delay.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pipe_delay.sv
// Multi-channel input pipeline with run-time selectable latency (0..DEPTH),
// per-stage valid tracking, clock-enable stall, flush and fill-based primed status.
module dsp_pipe_delay #(
   parameter int WIDTH    = 18,
   parameter int DEPTH    = 4,
   parameter int CHANNELS = 2,
   parameter int LAT_W    = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ce,
   input  logic                      flush,
   input  logic [LAT_W-1:0]          lat,
   input  logic                      in_valid,
   input  logic [CHANNELS*WIDTH-1:0] din,
   output logic [CHANNELS*WIDTH-1:0] dout,
   output logic                      out_valid,
   output logic                      primed,
   output logic                      lat_err
);

   localparam int               DW      = CHANNELS * WIDTH;
   localparam logic [LAT_W-1:0] DEPTH_L = LAT_W'(DEPTH);

   logic [DW-1:0]    s [1:DEPTH];
   logic [DEPTH:1]   v;
   logic [LAT_W-1:0] cnt;
   logic [LAT_W-1:0] lat_q;
   logic [LAT_W-1:0] lat_eff;

   always_comb begin
      lat_err = (lat > DEPTH_L);
      lat_eff = lat_err ? DEPTH_L : lat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 1; k <= DEPTH; k++) s[k] <= '0;
         v <= '0;
      end else if (flush) begin
         for (int unsigned k = 1; k <= DEPTH; k++) s[k] <= '0;
         v <= '0;
      end else if (ce) begin
         s[1] <= din;
         v[1] <= in_valid;
         for (int unsigned k = 2; k <= DEPTH; k++) begin
            s[k] <= s[k-1];
            v[k] <= v[k-1];
         end
      end
   end

   // A latency change restarts the fill count but leaves stage contents intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         lat_q <= '0;
      end else begin
         lat_q <= lat_eff;
         if (flush || (lat_eff != lat_q))
            cnt <= '0;
         else if (ce && (cnt != DEPTH_L))
            cnt <= cnt + LAT_W'(1);
      end
   end

   always_comb begin
      dout      = din;
      out_valid = in_valid;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
         if (lat_eff == LAT_W'(k)) begin
            dout      = s[k];
            out_valid = v[k];
         end
      end
   end

   assign primed = (cnt >= lat_eff) && (lat_eff == lat_q);

endmodule

// File: tb/tb_dsp_pipe_delay.sv
// Directed self-checking bench for dsp_pipe_delay (WIDTH=18, DEPTH=4, CHANNELS=2).
module tb_dsp_pipe_delay;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        flush;
   logic [2:0]  lat;
   logic        in_valid;
   logic [35:0] din;
   logic [35:0] dout;
   logic        out_valid;
   logic        primed;
   logic        lat_err;

   int n_checks = 0;
   int n_fail   = 0;

   dsp_pipe_delay #(
      .WIDTH    (18),
      .DEPTH    (4),
      .CHANNELS (2),
      .LAT_W    (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .flush     (flush),
      .lat       (lat),
      .in_valid  (in_valid),
      .din       (din),
      .dout      (dout),
      .out_valid (out_valid),
      .primed    (primed),
      .lat_err   (lat_err)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; ce = 1'b0; flush = 1'b0; lat = 3'd3; in_valid = 1'b1;
      din = {18'h00001, 18'h00002};
      #2;
      n_checks++; if (dout !== 36'h0) begin n_fail++; $display("FAIL rst_dout got %h exp %h", dout, 36'h0); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid); end
      n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL rst_primed_lat3 got %b exp 0", primed); end
      n_checks++; if (lat_err !== 1'b0) begin n_fail++; $display("FAIL rst_lat_err got %b exp 0", lat_err); end
      lat = 3'd0;
      #1;
      n_checks++; if (dout !== {18'h00001, 18'h00002}) begin n_fail++; $display("FAIL rst_bypass_dout got %h exp %h", dout, {18'h00001, 18'h00002}); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_bypass_valid got %b exp 1", out_valid); end
      n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL rst_primed_lat0 got %b exp 1", primed); end
      lat = 3'd3;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_latency3;
      for (int i = 1; i <= 8; i++) begin
         ce = 1'b1; in_valid = 1'b1;
         din = {18'(100 + i), 18'(i)};
         step;
         n_checks++;
         if (dout[17:0] !== ((i >= 3) ? 18'(i - 2) : 18'h0)) begin
            n_fail++; $display("FAIL lat3_lane0[%0d] got %h exp %h", i, dout[17:0], (i >= 3) ? 18'(i - 2) : 18'h0);
         end
         n_checks++;
         if (dout[35:18] !== ((i >= 3) ? 18'(100 + i - 2) : 18'h0)) begin
            n_fail++; $display("FAIL lat3_lane1[%0d] got %h exp %h", i, dout[35:18], (i >= 3) ? 18'(100 + i - 2) : 18'h0);
         end
         n_checks++;
         if (out_valid !== (i >= 3)) begin
            n_fail++; $display("FAIL lat3_valid[%0d] got %b exp %b", i, out_valid, (i >= 3));
         end
         n_checks++;
         if (primed !== (i >= 4)) begin
            n_fail++; $display("FAIL lat3_primed[%0d] got %b exp %b", i, primed, (i >= 4));
         end
      end
   endtask

   task automatic test_bypass;
      lat = 3'd0; ce = 1'b1; in_valid = 1'b1;
      din = {18'h15555, 18'h2AAAA};
      #1;
      n_checks++; if (dout !== {18'h15555, 18'h2AAAA}) begin n_fail++; $display("FAIL byp_dout0 got %h exp %h", dout, {18'h15555, 18'h2AAAA}); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid0 got %b exp 1", out_valid); end
      n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL byp_primed_change got %b exp 0", primed); end
      step;
      n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL byp_primed got %b exp 1", primed); end
      n_checks++; if (dout !== {18'h15555, 18'h2AAAA}) begin n_fail++; $display("FAIL byp_dout1 got %h exp %h", dout, {18'h15555, 18'h2AAAA}); end
      in_valid = 1'b0;
      din = {18'h2AAAA, 18'h15555};
      #1;
      n_checks++; if (dout !== {18'h2AAAA, 18'h15555}) begin n_fail++; $display("FAIL byp_dout2 got %h exp %h", dout, {18'h2AAAA, 18'h15555}); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_valid2 got %b exp 0", out_valid); end
   endtask

   task automatic test_stall;
      lat = 3'd2;
      for (int j = 1; j <= 3; j++) begin
         ce = 1'b1; in_valid = 1'b1;
         din = {18'h0, 18'(20 + j)};
         step;
         if (j >= 2) begin
            n_checks++; if (dout[17:0] !== 18'(20 + j - 1)) begin n_fail++; $display("FAIL stall_pre[%0d] got %h exp %h", j, dout[17:0], 18'(20 + j - 1)); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pre_valid[%0d] got %b exp 1", j, out_valid); end
         end
         n_checks++; if (primed !== (j == 3)) begin n_fail++; $display("FAIL stall_primed[%0d] got %b exp %b", j, primed, (j == 3)); end
      end
      ce = 1'b0; in_valid = 1'b0; din = '1;
      for (int j = 0; j < 2; j++) begin
         step;
         n_checks++; if (dout[17:0] !== 18'd22) begin n_fail++; $display("FAIL stall_hold[%0d] got %h exp %h", j, dout[17:0], 18'd22); end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid[%0d] got %b exp 1", j, out_valid); end
         n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL stall_hold_primed[%0d] got %b exp 1", j, primed); end
      end
      for (int j = 4; j <= 6; j++) begin
         ce = 1'b1; in_valid = 1'b1;
         din = {18'h0, 18'(20 + j)};
         step;
         n_checks++; if (dout[17:0] !== 18'(20 + j - 1)) begin n_fail++; $display("FAIL stall_resume[%0d] got %h exp %h", j, dout[17:0], 18'(20 + j - 1)); end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resume_valid[%0d] got %b exp 1", j, out_valid); end
      end
   endtask

   task automatic test_flush;
      lat = 3'd4; ce = 1'b1; in_valid = 1'b1;
      for (int j = 5; j <= 7; j++) begin
         din = {18'h0, 18'(j)};
         step;
      end
      flush = 1'b1; din = {18'h0, 18'd8};
      step;
      flush = 1'b0;
      n_checks++; if (dout !== 36'h0) begin n_fail++; $display("FAIL flush_dout got %h exp %h", dout, 36'h0); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
      n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL flush_primed got %b exp 0", primed); end
      for (int j = 1; j <= 4; j++) begin
         din = {18'(60 + j), 18'(40 + j)};
         step;
         n_checks++; if (out_valid !== (j == 4)) begin n_fail++; $display("FAIL refill_valid[%0d] got %b exp %b", j, out_valid, (j == 4)); end
         n_checks++; if (primed !== (j == 4)) begin n_fail++; $display("FAIL refill_primed[%0d] got %b exp %b", j, primed, (j == 4)); end
      end
      n_checks++; if (dout !== {18'd61, 18'd41}) begin n_fail++; $display("FAIL refill_dout got %h exp %h", dout, {18'd61, 18'd41}); end
   endtask

   task automatic test_lat_change;
      ce = 1'b0; lat = 3'd7;
      #1;
      n_checks++; if (lat_err !== 1'b1) begin n_fail++; $display("FAIL laterr_flag got %b exp 1", lat_err); end
      n_checks++; if (dout[17:0] !== 18'd41) begin n_fail++; $display("FAIL laterr_dout got %h exp %h", dout[17:0], 18'd41); end
      n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL laterr_primed got %b exp 1", primed); end
      step;
      n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL laterr_primed_hold got %b exp 1", primed); end
      lat = 3'd2;
      #1;
      n_checks++; if (lat_err !== 1'b0) begin n_fail++; $display("FAIL lat2_err got %b exp 0", lat_err); end
      n_checks++; if (dout[17:0] !== 18'd43) begin n_fail++; $display("FAIL lat2_dout got %h exp %h", dout[17:0], 18'd43); end
      n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL lat2_primed got %b exp 0", primed); end
      step;
      lat = 3'd3;
      #1;
      n_checks++; if (dout[17:0] !== 18'd42) begin n_fail++; $display("FAIL lat3sw_dout got %h exp %h", dout[17:0], 18'd42); end
      n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL lat3sw_primed got %b exp 0", primed); end
      step;
      for (int j = 1; j <= 3; j++) begin
         ce = 1'b1; in_valid = 1'b1;
         din = {18'h0, 18'(50 + j)};
         step;
         n_checks++;
         if (dout[17:0] !== ((j == 1) ? 18'd43 : (j == 2) ? 18'd44 : 18'd51)) begin
            n_fail++; $display("FAIL lat3sw_data[%0d] got %h exp %h", j, dout[17:0], (j == 1) ? 18'd43 : (j == 2) ? 18'd44 : 18'd51);
         end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat3sw_valid[%0d] got %b exp 1", j, out_valid); end
         n_checks++; if (primed !== (j == 3)) begin n_fail++; $display("FAIL lat3sw_primed[%0d] got %b exp %b", j, primed, (j == 3)); end
      end
   endtask

   task automatic test_async_reset;
      lat = 3'd3; ce = 1'b1; in_valid = 1'b1;
      for (int j = 1; j <= 2; j++) begin
         din = {18'h0, 18'(70 + j)};
         step;
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (dout !== 36'h0) begin n_fail++; $display("FAIL arst_dout got %h exp %h", dout, 36'h0); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b exp 0", out_valid); end
      n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL arst_primed got %b exp 0", primed); end
      step;
      n_checks++; if (dout !== 36'h0) begin n_fail++; $display("FAIL arst_hold_dout got %h exp %h", dout, 36'h0); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         din = {18'h0, 18'(80 + i)};
         step;
         n_checks++;
         if (dout[17:0] !== ((i >= 3) ? 18'(80 + i - 2) : 18'h0)) begin
            n_fail++; $display("FAIL arst_resume[%0d] got %h exp %h", i, dout[17:0], (i >= 3) ? 18'(80 + i - 2) : 18'h0);
         end
         n_checks++; if (out_valid !== (i >= 3)) begin n_fail++; $display("FAIL arst_resume_valid[%0d] got %b exp %b", i, out_valid, (i >= 3)); end
         n_checks++; if (primed !== (i >= 4)) begin n_fail++; $display("FAIL arst_resume_primed[%0d] got %b exp %b", i, primed, (i >= 4)); end
      end
   endtask

   initial begin
      test_reset;
      test_latency3;
      test_bypass;
      test_stall;
      test_flush;
      test_lat_change;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
